// File: rtl/altsyncram_mixed_sc.sv
// Single-clock true-dual-port RAM with mixed port widths over one shared array.
// Storage is kept as wide-port words; the narrow port addresses lanes within a word.
module altsyncram_mixed_sc #(
  parameter int    width_a                            = 32,
  parameter int    widthad_a                          = 8,
  parameter int    width_b                            = 8,
  parameter int    widthad_b                          = 10,
  parameter int    byte_size                          = 8,
  parameter string outdata_reg_a                      = "UNREGISTERED",
  parameter string outdata_reg_b                      = "UNREGISTERED",
  parameter string read_during_write_mode_port_a      = "OLD_DATA",
  parameter string read_during_write_mode_port_b      = "OLD_DATA",
  parameter string read_during_write_mode_mixed_ports = "OLD_DATA"
) (
  input  logic                           clock0,
  input  logic                           sclr,
  input  logic                           clocken0,
  input  logic [widthad_a-1:0]           address_a,
  input  logic [width_a/byte_size-1:0]   byteena_a,
  input  logic                           wren_a,
  input  logic                           rden_a,
  input  logic [width_a-1:0]             data_a,
  output logic [width_a-1:0]             q_a,
  input  logic [widthad_b-1:0]           address_b,
  input  logic [width_b/byte_size-1:0]   byteena_b,
  input  logic                           wren_b,
  input  logic                           rden_b,
  input  logic [width_b-1:0]             data_b,
  output logic [width_b-1:0]             q_b
);

  localparam int unsigned W     = (width_a > width_b) ? width_a : width_b;
  localparam int unsigned N     = (width_a > width_b) ? width_b : width_a;
  localparam int unsigned RA    = W / width_a;
  localparam int unsigned RB    = W / width_b;
  localparam int unsigned AW    = (width_a >= width_b) ? widthad_a : widthad_b;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned NBA   = width_a / byte_size;
  localparam int unsigned NBB   = width_b / byte_size;

  localparam int unsigned RDW_OLD    = 0;
  localparam int unsigned RDW_NBE    = 1;
  localparam int unsigned RDW_NO_NBE = 2;
  localparam int unsigned RDW_BAD    = 3;

  localparam int unsigned MODE_A =
    (read_during_write_mode_port_a == "OLD_DATA")               ? RDW_OLD :
    (read_during_write_mode_port_a == "NEW_DATA_WITH_NBE_READ") ? RDW_NBE :
    (read_during_write_mode_port_a == "NEW_DATA_NO_NBE_READ")   ? RDW_NO_NBE : RDW_BAD;
  localparam int unsigned MODE_B =
    (read_during_write_mode_port_b == "OLD_DATA")               ? RDW_OLD :
    (read_during_write_mode_port_b == "NEW_DATA_WITH_NBE_READ") ? RDW_NBE :
    (read_during_write_mode_port_b == "NEW_DATA_NO_NBE_READ")   ? RDW_NO_NBE : RDW_BAD;
  localparam bit MIX_NEW = (read_during_write_mode_mixed_ports == "NEW_DATA");
  localparam bit MIX_OK  = MIX_NEW || (read_during_write_mode_mixed_ports == "OLD_DATA");
  localparam bit REG_A   = (outdata_reg_a == "CLOCK0");
  localparam bit REG_B   = (outdata_reg_b == "CLOCK0");
  localparam bit REG_OK  = (REG_A || outdata_reg_a == "UNREGISTERED") &&
                           (REG_B || outdata_reg_b == "UNREGISTERED");

  if ((W % N) != 0 || ((W / N) & ((W / N) - 1)) != 0) begin : g_bad_ratio
    $error("altsyncram_mixed_sc: width_a/width_b ratio is not a power of two");
  end
  if (width_a * (2 ** widthad_a) != width_b * (2 ** widthad_b)) begin : g_bad_total
    $error("altsyncram_mixed_sc: total bits differ between ports");
  end
  if ((width_a % byte_size) != 0 || (width_b % byte_size) != 0) begin : g_bad_byte
    $error("altsyncram_mixed_sc: port width is not a multiple of byte_size");
  end
  if (MODE_A == RDW_BAD || MODE_B == RDW_BAD || !MIX_OK || !REG_OK) begin : g_bad_mode
    $error("altsyncram_mixed_sc: unknown mode string");
  end

  logic [W-1:0]       r_mem [DEPTH];
  logic [width_a-1:0] r_qi_a, r_qr_a;
  logic [width_b-1:0] r_qi_b, r_qr_b;

  logic               w_wr_a, w_wr_b, w_rd_en_a, w_rd_en_b, w_same;
  logic [AW-1:0]      w_word_a, w_word_b;
  logic [31:0]        w_sh_a, w_sh_b;
  logic [W-1:0]       w_ma, w_mb, w_da, w_db;
  logic [W-1:0]       w_old_a, w_old_b, w_post_a, w_post_b;
  logic [width_a-1:0] w_rd_a;
  logic [width_b-1:0] w_rd_b;

  assign w_wr_a    = clocken0 && wren_a && !sclr;
  assign w_wr_b    = clocken0 && wren_b && !sclr;
  assign w_rd_en_a = clocken0 && rden_a && !sclr;
  assign w_rd_en_b = clocken0 && rden_b && !sclr;

  // Each port's access is mapped to a wide word index, a bit offset and a byte mask.
  always_comb begin : p_map
    logic [width_a-1:0] be_bits_a;
    logic [width_b-1:0] be_bits_b;
    be_bits_a = '0;
    be_bits_b = '0;
    for (int unsigned i = 0; i < NBA; i++) be_bits_a[i*byte_size +: byte_size] = {byte_size{byteena_a[i]}};
    for (int unsigned i = 0; i < NBB; i++) be_bits_b[i*byte_size +: byte_size] = {byte_size{byteena_b[i]}};
    w_word_a = AW'(32'(address_a) / RA);
    w_word_b = AW'(32'(address_b) / RB);
    w_sh_a   = (32'(address_a) % RA) * width_a;
    w_sh_b   = (32'(address_b) % RB) * width_b;
    w_ma     = W'(be_bits_a) << w_sh_a;
    w_mb     = W'(be_bits_b) << w_sh_b;
    w_da     = W'(data_a) << w_sh_a;
    w_db     = W'(data_b) << w_sh_b;
  end

  assign w_same  = (w_word_a == w_word_b);
  assign w_old_a = r_mem[w_word_a];
  assign w_old_b = r_mem[w_word_b];

  // Post-write word contents; B is applied last so it wins on overlapping bytes.
  always_comb begin : p_post
    w_post_a = w_old_a;
    if (w_wr_a)           w_post_a = (w_post_a & ~w_ma) | (w_da & w_ma);
    if (w_wr_b && w_same) w_post_a = (w_post_a & ~w_mb) | (w_db & w_mb);
    w_post_b = w_old_b;
    if (w_wr_a && w_same) w_post_b = (w_post_b & ~w_ma) | (w_da & w_ma);
    if (w_wr_b)           w_post_b = (w_post_b & ~w_mb) | (w_db & w_mb);
  end

  always_comb begin : p_read
    logic [W-1:0] ra, rb;
    ra = w_old_a;
    if (MIX_NEW && w_wr_b && w_same) ra = (ra & ~w_mb) | (w_post_a & w_mb);
    if (w_wr_a) begin
      if (MODE_A == RDW_NBE)         ra = (ra & ~w_ma) | (w_post_a & w_ma);
      else if (MODE_A == RDW_NO_NBE) ra = w_post_a & w_ma;
    end
    rb = w_old_b;
    if (MIX_NEW && w_wr_a && w_same) rb = (rb & ~w_ma) | (w_post_b & w_ma);
    if (w_wr_b) begin
      if (MODE_B == RDW_NBE)         rb = (rb & ~w_mb) | (w_post_b & w_mb);
      else if (MODE_B == RDW_NO_NBE) rb = w_post_b & w_mb;
    end
    w_rd_a = width_a'(ra >> w_sh_a);
    w_rd_b = width_b'(rb >> w_sh_b);
  end

  always_ff @(posedge clock0) begin
    if (w_wr_a) r_mem[w_word_a] <= w_post_a;
    if (w_wr_b) r_mem[w_word_b] <= w_post_b;
  end

  always_ff @(posedge clock0) begin
    if (sclr) begin
      r_qi_a <= '0;
      r_qr_a <= '0;
      r_qi_b <= '0;
      r_qr_b <= '0;
    end else if (clocken0) begin
      if (rden_a) r_qi_a <= w_rd_a;
      if (rden_b) r_qi_b <= w_rd_b;
      r_qr_a <= r_qi_a;
      r_qr_b <= r_qi_b;
    end
  end

  assign q_a = REG_A ? r_qr_a : r_qi_a;
  assign q_b = REG_B ? r_qr_b : r_qi_b;

endmodule

// File: tb/tb_altsyncram_mixed_sc.sv
// Bench for altsyncram_mixed_sc: four configurations share one stimulus stream and
// are checked against a byte-addressed reference memory.
module tb_altsyncram_mixed_sc;

  logic        clk = 1'b0;
  logic        sclr, ce;
  logic [7:0]  addr_a;
  logic [3:0]  be_a;
  logic        wren_a, rden_a;
  logic [31:0] data_a;
  logic [9:0]  addr_b;
  logic [0:0]  be_b;
  logic        wren_b, rden_b;
  logic [7:0]  data_b;
  logic [31:0] qa [4];
  logic [7:0]  qb [4];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Variant 0: defaults. 1: A with-NBE, B no-NBE, mixed new. 2: A no-NBE, B with-NBE. 3: both registered.
  altsyncram_mixed_sc u_dflt (
    .clock0(clk), .sclr(sclr), .clocken0(ce),
    .address_a(addr_a), .byteena_a(be_a), .wren_a(wren_a), .rden_a(rden_a), .data_a(data_a), .q_a(qa[0]),
    .address_b(addr_b), .byteena_b(be_b), .wren_b(wren_b), .rden_b(rden_b), .data_b(data_b), .q_b(qb[0]));

  altsyncram_mixed_sc #(
    .read_during_write_mode_port_a("NEW_DATA_WITH_NBE_READ"),
    .read_during_write_mode_port_b("NEW_DATA_NO_NBE_READ"),
    .read_during_write_mode_mixed_ports("NEW_DATA")
  ) u_nbe (
    .clock0(clk), .sclr(sclr), .clocken0(ce),
    .address_a(addr_a), .byteena_a(be_a), .wren_a(wren_a), .rden_a(rden_a), .data_a(data_a), .q_a(qa[1]),
    .address_b(addr_b), .byteena_b(be_b), .wren_b(wren_b), .rden_b(rden_b), .data_b(data_b), .q_b(qb[1]));

  altsyncram_mixed_sc #(
    .read_during_write_mode_port_a("NEW_DATA_NO_NBE_READ"),
    .read_during_write_mode_port_b("NEW_DATA_WITH_NBE_READ")
  ) u_nno (
    .clock0(clk), .sclr(sclr), .clocken0(ce),
    .address_a(addr_a), .byteena_a(be_a), .wren_a(wren_a), .rden_a(rden_a), .data_a(data_a), .q_a(qa[2]),
    .address_b(addr_b), .byteena_b(be_b), .wren_b(wren_b), .rden_b(rden_b), .data_b(data_b), .q_b(qb[2]));

  altsyncram_mixed_sc #(
    .outdata_reg_a("CLOCK0"),
    .outdata_reg_b("CLOCK0")
  ) u_reg (
    .clock0(clk), .sclr(sclr), .clocken0(ce),
    .address_a(addr_a), .byteena_a(be_a), .wren_a(wren_a), .rden_a(rden_a), .data_a(data_a), .q_a(qa[3]),
    .address_b(addr_b), .byteena_b(be_b), .wren_b(wren_b), .rden_b(rden_b), .data_b(data_b), .q_b(qb[3]));

  // Reference: memory as 1024 bytes; A word n = bytes 4n..4n+3 (LSB first), B word n = byte n.
  logic [7:0]  m [1024];
  logic [31:0] eqi_a [4], eqr_a [4];
  logic [7:0]  eqi_b [4], eqr_b [4];
  int          mode_a [4] = '{0, 1, 2, 0};
  int          mode_b [4] = '{0, 2, 1, 0};
  bit          mix_new [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit          is_reg [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  function automatic bit a_wr(int b);
    return wren_a && (b / 4 == int'(addr_a)) && be_a[b % 4];
  endfunction

  function automatic bit b_wr(int b);
    return wren_b && (b == int'(addr_b)) && be_b[0];
  endfunction

  function automatic logic [7:0] new_byte(int b);
    logic [7:0] v;
    v = m[b];
    if (a_wr(b)) v = data_a[8*(b % 4) +: 8];
    if (b_wr(b)) v = data_b;
    return v;
  endfunction

  // mode: 0 old data, 1 new data with old unenabled bytes, 2 new data with zeroed unenabled bytes.
  function automatic logic [7:0] rd_byte(int b, bit own_en, bit own_writing, int mode, bit mixn, bit other_en);
    logic [7:0] r;
    r = m[b];
    if (mixn && other_en) r = new_byte(b);
    if (own_writing) begin
      if (mode == 1 && own_en) r = new_byte(b);
      if (mode == 2) r = own_en ? new_byte(b) : 8'h00;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_a(int v);
    return is_reg[v] ? eqr_a[v] : eqi_a[v];
  endfunction

  function automatic logic [7:0] exp_b(int v);
    return is_reg[v] ? eqr_b[v] : eqi_b[v];
  endfunction

  // Advance the reference by one clock with the currently driven inputs, then clock the DUTs.
  task automatic tick();
    logic [7:0] na [4];
    logic [7:0] nb;
    int         ba, bb;
    ba = 4 * int'(addr_a);
    bb = int'(addr_b);
    if (sclr) begin
      for (int v = 0; v < 4; v++) begin
        eqi_a[v] = '0; eqr_a[v] = '0; eqi_b[v] = '0; eqr_b[v] = '0;
      end
    end else if (ce) begin
      for (int v = 0; v < 4; v++) begin
        eqr_a[v] = eqi_a[v];
        eqr_b[v] = eqi_b[v];
        if (rden_a)
          for (int k = 0; k < 4; k++)
            eqi_a[v][8*k +: 8] = rd_byte(ba + k, a_wr(ba + k), wren_a, mode_a[v], mix_new[v], b_wr(ba + k));
        if (rden_b)
          eqi_b[v] = rd_byte(bb, b_wr(bb), wren_b, mode_b[v], mix_new[v], a_wr(bb));
      end
      for (int k = 0; k < 4; k++) na[k] = new_byte(ba + k);
      nb = new_byte(bb);
      for (int k = 0; k < 4; k++) m[ba + k] = na[k];
      m[bb] = nb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
    be_a = 4'hF; be_b = 1'b1; sclr = 1'b0; ce = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    for (int v = 0; v < 4; v++) begin
      n_checks++;
      if (qa[v] !== 32'h0) $display("FAIL reset_q_a[%0d] got %h want 00000000", v, qa[v]);
      else n_pass++;
      n_checks++;
      if (qb[v] !== 8'h0) $display("FAIL reset_q_b[%0d] got %h want 00", v, qb[v]);
      else n_pass++;
    end
  endtask

  task automatic test_wide_to_narrow();
    logic [7:0] want [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    idle();
    wren_a = 1'b1; addr_a = 8'd3; data_a = 32'hDDCCBBAA;
    tick();
    idle();
    rden_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_b = 10'(12 + i);
      tick();
      n_checks++;
      if (qb[0] !== want[i]) $display("FAIL narrow_read addr %0d got %h want %h", 12 + i, qb[0], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_narrow_to_wide();
    idle();
    wren_b = 1'b1; addr_b = 10'd13; data_b = 8'h55;
    tick();
    idle();
    rden_a = 1'b1; addr_a = 8'd3;
    tick();
    n_checks++;
    if (qa[0] !== 32'hDDCC55AA) $display("FAIL narrow_write got %h want DDCC55AA", qa[0]);
    else n_pass++;
  endtask

  task automatic test_byteena();
    idle();
    wren_a = 1'b1; addr_a = 8'd3; data_a = 32'h11223344; be_a = 4'b0101;
    tick();
    idle();
    rden_a = 1'b1; addr_a = 8'd3;
    tick();
    n_checks++;
    if (qa[0] !== 32'hDD225544) $display("FAIL byteena got %h want DD225544", qa[0]);
    else n_pass++;
  endtask

  task automatic test_rdw_same_port();
    logic [31:0] pre [2]       = '{32'h00000000, 32'h12345678};
    logic [31:0] want_old [2]  = '{32'h00000000, 32'h12345678};
    logic [31:0] want_nbe [2]  = '{32'h000000FF, 32'h123456FF};
    logic [31:0] want_none [2] = '{32'h000000FF, 32'h000000FF};
    for (int i = 0; i < 2; i++) begin
      idle();
      wren_a = 1'b1; addr_a = 8'd5; data_a = pre[i];
      tick();
      rden_a = 1'b1; data_a = 32'hFFFFFFFF; be_a = 4'b0001;
      tick();
      n_checks++;
      if (qa[0] !== want_old[i]) $display("FAIL rdw_old[%0d] got %h want %h", i, qa[0], want_old[i]);
      else n_pass++;
      n_checks++;
      if (qa[1] !== want_nbe[i]) $display("FAIL rdw_with_nbe[%0d] got %h want %h", i, qa[1], want_nbe[i]);
      else n_pass++;
      n_checks++;
      if (qa[2] !== want_none[i]) $display("FAIL rdw_no_nbe[%0d] got %h want %h", i, qa[2], want_none[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mixed_ports();
    idle();
    wren_a = 1'b1; addr_a = 8'd0; data_a = 32'h00000000;
    wren_b = 1'b1; addr_b = 10'd1; data_b = 8'hFF;
    tick();
    idle();
    rden_a = 1'b1; addr_a = 8'd0;
    tick();
    n_checks++;
    if (qa[0] !== 32'h0000FF00) $display("FAIL dual_write got %h want 0000FF00", qa[0]);
    else n_pass++;
    // Overlapping write: B's byte must win.
    idle();
    wren_a = 1'b1; addr_a = 8'd0; data_a = 32'hAAAAAAAA;
    wren_b = 1'b1; addr_b = 10'd1; data_b = 8'h77;
    tick();
    idle();
    rden_a = 1'b1; addr_a = 8'd0;
    tick();
    n_checks++;
    if (qa[0] !== 32'hAAAA77AA) $display("FAIL collision got %h want AAAA77AA", qa[0]);
    else n_pass++;
    // A reads the word B is writing.
    wren_b = 1'b1; addr_b = 10'd1; data_b = 8'h33;
    tick();
    n_checks++;
    if (qa[0] !== 32'hAAAA77AA) $display("FAIL mixed_old got %h want AAAA77AA", qa[0]);
    else n_pass++;
    n_checks++;
    if (qa[1] !== 32'hAAAA33AA) $display("FAIL mixed_new got %h want AAAA33AA", qa[1]);
    else n_pass++;
  endtask

  task automatic test_outreg_sclr();
    idle();
    rden_a = 1'b1; addr_a = 8'd0;
    tick();
    tick();
    n_checks++;
    if (qa[3] !== 32'hAAAA33AA) $display("FAIL reg_prime got %h want AAAA33AA", qa[3]);
    else n_pass++;
    addr_a = 8'd3;
    tick();
    rden_a = 1'b0;
    n_checks++;
    if (qa[3] !== 32'hAAAA33AA) $display("FAIL reg_latency1 got %h want AAAA33AA", qa[3]);
    else n_pass++;
    tick();
    n_checks++;
    if (qa[3] !== 32'hDD225544) $display("FAIL reg_latency2 got %h want DD225544", qa[3]);
    else n_pass++;
    rden_a = 1'b1; addr_a = 8'd0;
    tick();
    tick();
    addr_a = 8'd3;
    tick();
    rden_a = 1'b0; sclr = 1'b1;
    tick();
    n_checks++;
    if (qa[3] !== 32'h0) $display("FAIL sclr_clear got %h want 00000000", qa[3]);
    else n_pass++;
    sclr = 1'b0;
    tick();
    n_checks++;
    if (qa[3] !== 32'h0) $display("FAIL sclr_discard got %h want 00000000", qa[3]);
    else n_pass++;
    rden_a = 1'b1; addr_a = 8'd3;
    tick();
    rden_a = 1'b0;
    tick();
    n_checks++;
    if (qa[3] !== 32'hDD225544) $display("FAIL sclr_retain got %h want DD225544", qa[3]);
    else n_pass++;
  endtask

  task automatic test_random();
    idle();
    for (int w = 1; w < 3; w++) begin
      wren_a = 1'b1; addr_a = 8'(w); data_a = $urandom;
      tick();
    end
    for (int c = 0; c < 400; c++) begin
      ce     = ($urandom_range(0, 9) != 0);
      sclr   = ($urandom_range(0, 24) == 0);
      addr_a = 8'($urandom_range(0, 3));
      addr_b = 10'($urandom_range(0, 15));
      be_a   = 4'($urandom);
      be_b   = 1'($urandom);
      wren_a = 1'($urandom);
      rden_a = 1'($urandom);
      wren_b = 1'($urandom);
      rden_b = 1'($urandom);
      data_a = $urandom;
      data_b = 8'($urandom);
      tick();
      for (int v = 0; v < 4; v++) begin
        n_checks++;
        if (qa[v] !== exp_a(v)) $display("FAIL rand_q_a[%0d] cycle %0d got %h want %h", v, c, qa[v], exp_a(v));
        else n_pass++;
        n_checks++;
        if (qb[v] !== exp_b(v)) $display("FAIL rand_q_b[%0d] cycle %0d got %h want %h", v, c, qb[v], exp_b(v));
        else n_pass++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m[i] = 8'h00;
    for (int v = 0; v < 4; v++) begin
      eqi_a[v] = '0; eqr_a[v] = '0; eqi_b[v] = '0; eqr_b[v] = '0;
    end
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    idle();
    test_reset();
    test_wide_to_narrow();
    test_narrow_to_wide();
    test_byteena();
    test_rdw_same_port();
    test_mixed_ports();
    test_outreg_sclr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
